sram_controller: RTL and testbench

Multi-cycle controller sequencing the off-chip 16-bit SRAM on behalf of the MEM stage. Splits each 32-bit load/store into two half-word SRAM accesses with programmable wait states. Drops `ready` while an access is in flight; top level ORs `~ready` into the pipeline freeze so IF through MEM hold until the access completes. Replaces the single-cycle data memory inside Mem_Stage.

---
 rtl/sram_controller.sv | 151 +++++++++++++++
 tb/tb_sram_controller.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_controller.sv
// -----------------------------------------------------------------------------
// sram_controller
//
// Sequences the off-chip 16-bit SRAM for the MEM stage. Each 32-bit load or
// store becomes two half-word accesses (low half first, then high half), and
// each half-word access lasts WAIT_CYCLES clocks. `ready` stays low while an
// access is in flight so the pipeline freeze holds address/wdata stable.
//
// Parameters:
//   BASE_ADDR    byte address that maps to SRAM half-word 0
//   ADDR_WIDTH   SRAM half-word address width
//   WAIT_CYCLES  clocks per half-word access (1..15)
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous reset, active low
//   mem_read     load request
//   mem_write    store request (wins if both are asserted)
//   address      byte address
//   wdata        store data
//   rdata        load data, registered, held until the next load
//   ready        low = freeze the pipeline
//   sram_addr    SRAM half-word address
//   sram_we_n    SRAM write enable, active low
//   sram_dq_out  SRAM write data
//   sram_dq_oe   output enable for sram_dq_out (pad lives at top level)
//   sram_dq_in   SRAM read data
// -----------------------------------------------------------------------------
module sram_controller #(
  parameter logic [31:0] BASE_ADDR   = 32'd1024,
  parameter int          ADDR_WIDTH  = 18,
  parameter int          WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [31:0]           address,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata,
  output logic                  ready,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic                  sram_we_n,
  output logic [15:0]           sram_dq_out,
  output logic                  sram_dq_oe,
  input  logic [15:0]           sram_dq_in
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOW  = 2'd1;
  localparam logic [1:0] HIGH = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        is_write_q, is_write_d;
  logic [31:0] rdata_q, rdata_d;

  logic                  req;
  logic                  in_access;
  logic                  high_half;
  logic                  drive;
  logic [ADDR_WIDTH-1:0] hw_low_addr;

  assign req = mem_read | mem_write;

  // Half-word address of the low half: word index shifted up one bit. The
  // subtraction wraps modulo 2^32 and the cast truncates silently, so byte
  // addresses below BASE_ADDR alias onto the top of the SRAM.
  assign hw_low_addr = ADDR_WIDTH'(((address - BASE_ADDR) >> 2) << 1);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned;
    // an incomplete assignment in combinational logic would infer a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    is_write_d = is_write_q;
    rdata_d    = rdata_q;

    case (state_q)
      IDLE: begin
        if (req) begin
          state_d    = LOW;
          cnt_d      = 4'd0;
          is_write_d = mem_write;
        end
      end
      LOW: begin
        if (cnt_q == LAST_CNT) begin
          state_d = HIGH;
          cnt_d   = 4'd0;
          if (!is_write_q) rdata_d[15:0] = sram_dq_in;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      HIGH: begin
        if (cnt_q == LAST_CNT) begin
          state_d = DONE;
          cnt_d   = 4'd0;
          if (!is_write_q) rdata_d[31:16] = sram_dq_in;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: state_d = IDLE;  // DONE always returns to IDLE
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      is_write_q <= 1'b0;
      rdata_q    <= 32'd0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values,
      // independent of statement order.
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      is_write_q <= is_write_d;
      rdata_q    <= rdata_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs, decoded from registered state. Because reset clears state_q
  // asynchronously, sram_we_n rises immediately on reset without a clock.
  // ---------------------------------------------------------------------------
  assign in_access = (state_q == LOW) || (state_q == HIGH);
  assign high_half = (state_q == HIGH);
  assign drive     = in_access && is_write_q;

  assign sram_addr   = in_access ? (hw_low_addr | ADDR_WIDTH'(high_half)) : '0;
  assign sram_we_n   = ~drive;
  assign sram_dq_oe  = drive;
  assign sram_dq_out = drive ? (high_half ? wdata[31:16] : wdata[15:0]) : 16'd0;

  // Combinational path from req keeps zero added latency when idle.
  assign ready = ~req | (state_q == DONE);
  assign rdata = rdata_q;

endmodule

// File: tb/tb_sram_controller.sv
// -----------------------------------------------------------------------------
// tb_sram_controller
//
// Two controller instances: u_dut0 with WAIT_CYCLES=2 and u_dut1 with
// WAIT_CYCLES=1, each attached to its own behavioural SRAM array. Expected
// values come from a word-level reference memory keyed by word index and from
// plain latency arithmetic (LOW = cycles 1..W, HIGH = W+1..2W, DONE = 2W+1).
// -----------------------------------------------------------------------------
module tb_sram_controller;

  localparam logic [31:0] BASE     = 32'd1024;
  localparam int          AW       = 18;
  localparam int          HW_WORDS = 1 << AW;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        mem_read    [2];
  logic        mem_write   [2];
  logic [31:0] address     [2];
  logic [31:0] wdata       [2];
  logic [31:0] rdata       [2];
  logic        ready       [2];
  logic [AW-1:0] sram_addr [2];
  logic        sram_we_n   [2];
  logic [15:0] sram_dq_out [2];
  logic        sram_dq_oe  [2];
  logic [15:0] sram_dq_in  [2];

  // Bench-side preload port into the SRAM models.
  logic        pl_en   [2];
  logic [16:0] pl_key  [2];
  logic [31:0] pl_data [2];

  sram_controller #(.BASE_ADDR(BASE), .ADDR_WIDTH(AW), .WAIT_CYCLES(2)) u_dut0 (
    .clk(clk), .rst(rst), .mem_read(mem_read[0]), .mem_write(mem_write[0]),
    .address(address[0]), .wdata(wdata[0]), .rdata(rdata[0]), .ready(ready[0]),
    .sram_addr(sram_addr[0]), .sram_we_n(sram_we_n[0]), .sram_dq_out(sram_dq_out[0]),
    .sram_dq_oe(sram_dq_oe[0]), .sram_dq_in(sram_dq_in[0])
  );

  sram_controller #(.BASE_ADDR(BASE), .ADDR_WIDTH(AW), .WAIT_CYCLES(1)) u_dut1 (
    .clk(clk), .rst(rst), .mem_read(mem_read[1]), .mem_write(mem_write[1]),
    .address(address[1]), .wdata(wdata[1]), .rdata(rdata[1]), .ready(ready[1]),
    .sram_addr(sram_addr[1]), .sram_we_n(sram_we_n[1]), .sram_dq_out(sram_dq_out[1]),
    .sram_dq_oe(sram_dq_oe[1]), .sram_dq_in(sram_dq_in[1])
  );

  // Asynchronous-read SRAM, written on the clock edge while we_n is low.
  logic [15:0] sram_mem [2][HW_WORDS];
  assign sram_dq_in[0] = sram_mem[0][sram_addr[0]];
  assign sram_dq_in[1] = sram_mem[1][sram_addr[1]];

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (pl_en[d]) begin
        sram_mem[d][{pl_key[d], 1'b0}] <= pl_data[d][15:0];
        sram_mem[d][{pl_key[d], 1'b1}] <= pl_data[d][31:16];
      end
      if (!sram_we_n[d]) sram_mem[d][sram_addr[d]] <= sram_dq_out[d];
    end
  end

  // Reference model: word contents keyed by {instance, word index}, plus the
  // last loaded value of each instance.
  logic [31:0] ref_mem [logic [17:0]];
  logic [31:0] exp_rdata [2];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Word index inside the SRAM: (address - BASE) / 4, modulo the SRAM size.
  function automatic logic [16:0] key_of(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return 17'(off / 4);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input int d, input logic [16:0] k, input logic [31:0] v);
    pl_en[d] = 1'b1; pl_key[d] = k; pl_data[d] = v;
    step();
    pl_en[d] = 1'b0;
    ref_mem[{d[0], k}] = v;
  endtask

  // Drop the request and check one idle cycle.
  task automatic go_idle(input int d);
    mem_read[d] = 1'b0; mem_write[d] = 1'b0;
    step();
    check($sformatf("d%0d_idle_ready", d), 32'(ready[d]), 1);
    check($sformatf("d%0d_idle_we_n", d), 32'(sram_we_n[d]), 1);
    check($sformatf("d%0d_idle_oe", d), 32'(sram_dq_oe[d]), 0);
    check($sformatf("d%0d_idle_addr", d), 32'(sram_addr[d]), 0);
    check($sformatf("d%0d_idle_dq", d), 32'(sram_dq_out[d]), 0);
  endtask

  // One full access, entered with the instance in IDLE; returns in DONE with
  // the request still applied.
  task automatic access(input int d, input bit rd, input bit wr,
                        input logic [31:0] a, input logic [31:0] wd);
    int          w;
    logic [16:0] k;
    logic [17:0] hw;
    logic [15:0] exp_dq;
    w = (d == 0) ? 2 : 1;
    k = key_of(a);
    mem_read[d] = rd; mem_write[d] = wr; address[d] = a; wdata[d] = wd;
    #1;
    check($sformatf("d%0d_c0_ready", d), 32'(ready[d]), 0);
    for (int c = 1; c <= 2 * w; c++) begin
      step();
      hw     = 18'(k) * 18'd2 + ((c > w) ? 18'd1 : 18'd0);
      exp_dq = wr ? ((c > w) ? wd[31:16] : wd[15:0]) : 16'd0;
      check($sformatf("d%0d_c%0d_ready", d, c), 32'(ready[d]), 0);
      check($sformatf("d%0d_c%0d_addr", d, c), 32'(sram_addr[d]), 32'(hw));
      check($sformatf("d%0d_c%0d_we_n", d, c), 32'(sram_we_n[d]), wr ? 0 : 1);
      check($sformatf("d%0d_c%0d_oe", d, c), 32'(sram_dq_oe[d]), wr ? 1 : 0);
      check($sformatf("d%0d_c%0d_dq", d, c), 32'(sram_dq_out[d]), 32'(exp_dq));
    end
    step();
    if (wr) ref_mem[{d[0], k}] = wd;
    else    exp_rdata[d] = ref_mem[{d[0], k}];
    check($sformatf("d%0d_done_ready", d), 32'(ready[d]), 1);
    check($sformatf("d%0d_done_rdata", d), rdata[d], exp_rdata[d]);
    check($sformatf("d%0d_done_we_n", d), 32'(sram_we_n[d]), 1);
    check($sformatf("d%0d_done_addr", d), 32'(sram_addr[d]), 0);
  endtask

  initial begin
    int          prev_d;
    bit          chain;
    int          d;
    int          op;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] old;
    logic [16:0] k;

    for (int i = 0; i < 2; i++) begin
      mem_read[i] = 1'b0; mem_write[i] = 1'b0; address[i] = '0; wdata[i] = '0;
      pl_en[i] = 1'b0; pl_key[i] = '0; pl_data[i] = '0; exp_rdata[i] = '0;
    end

    // Reset with a store request pending.
    rst = 1'b0;
    mem_write[0] = 1'b1;
    #1;
    check("rst_we_n", 32'(sram_we_n[0]), 1);
    check("rst_oe", 32'(sram_dq_oe[0]), 0);
    check("rst_rdata", rdata[0], 0);
    check("rst_ready_req", 32'(ready[0]), 0);
    check("rst_addr", 32'(sram_addr[0]), 0);
    check("rst_ready_noreq", 32'(ready[1]), 1);
    mem_write[0] = 1'b0;
    step();
    step();
    rst = 1'b1;
    go_idle(0);
    go_idle(1);

    // Seed word window 0..15 and the wrapped word just below BASE.
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 16; j++) preload(i, 17'(j), $urandom);
      preload(i, 17'h1FFFF, $urandom);
    end

    // Directed store / load at 1028, W=2.
    access(0, 1'b0, 1'b1, 32'd1028, 32'hDEADBEEF);
    go_idle(0);
    check("sram_hw2", 32'(sram_mem[0][2]), 32'h0000BEEF);
    check("sram_hw3", 32'(sram_mem[0][3]), 32'h0000DEAD);
    access(0, 1'b1, 1'b0, 32'd1028, 32'h0);
    go_idle(0);
    check("load_1028", rdata[0], 32'hDEADBEEF);

    // Back-to-back store then load at 1024, W=1: next access starts right
    // in the IDLE cycle after DONE.
    wd = $urandom;
    access(1, 1'b0, 1'b1, 32'd1024, wd);
    step();
    access(1, 1'b1, 1'b0, 32'd1024, 32'h0);
    check("b2b_load", rdata[1], wd);
    go_idle(1);

    // Below-base address wraps onto the top two half-words.
    wd = $urandom;
    access(1, 1'b0, 1'b1, 32'd1020, wd);
    go_idle(1);
    check("wrap_lo", 32'(sram_mem[1][HW_WORDS-2]), 32'(wd[15:0]));
    check("wrap_hi", 32'(sram_mem[1][HW_WORDS-1]), 32'(wd[31:16]));
    access(1, 1'b1, 1'b0, 32'd1020, 32'h0);
    go_idle(1);

    // Read and write together performs a write; rdata stays put.
    access(0, 1'b1, 1'b1, 32'd1032, 32'h12345678);
    go_idle(0);
    check("rw_rdata_kept", rdata[0], 32'hDEADBEEF);

    // Random mix of loads/stores, chained or separated, on both instances.
    prev_d = -1;
    for (int i = 0; i < 60; i++) begin
      d     = int'($urandom_range(0, 1));
      op    = int'($urandom_range(0, 3));
      chain = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 4) == 0) a = BASE - 32'd4 + 32'($urandom_range(0, 3));
      else                           a = BASE + 32'($urandom_range(0, 63));
      wd = $urandom;
      if (prev_d >= 0) begin
        if (chain && prev_d == d) step();
        else go_idle(prev_d);
      end
      access(d, op != 2, op >= 2, a, wd);
      prev_d = d;
    end
    go_idle(prev_d);

    // Reset during HIGH of a store aborts it with the low half already written.
    k   = key_of(32'd1028);
    old = ref_mem[{1'b0, k}];
    wd  = $urandom;
    mem_write[0] = 1'b1; address[0] = 32'd1028; wdata[0] = wd;
    for (int c = 1; c <= 3; c++) step();
    check("abort_high_we_n", 32'(sram_we_n[0]), 0);
    rst = 1'b0;
    #1;
    check("abort_we_n", 32'(sram_we_n[0]), 1);
    check("abort_oe", 32'(sram_dq_oe[0]), 0);
    check("abort_addr", 32'(sram_addr[0]), 0);
    check("abort_rdata", rdata[0], 0);
    check("abort_ready", 32'(ready[0]), 0);
    exp_rdata[0] = '0;
    exp_rdata[1] = '0;
    ref_mem[{1'b0, k}] = {old[31:16], wd[15:0]};
    mem_write[0] = 1'b0;
    #1;
    check("abort_ready_noreq", 32'(ready[0]), 1);
    step();
    rst = 1'b1;
    step();
    access(0, 1'b1, 1'b0, 32'd1028, 32'h0);
    go_idle(0);
    check("abort_reload", rdata[0], {old[31:16], wd[15:0]});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
